// File: rtl/instr_mem_loader.sv
// Instruction memory writer: packs a big-endian byte stream into 32-bit words.
// Optional trailing zero fill of unused words when LOADER_ZERO_FILL_EN is defined.
module instr_mem_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             byte_last_i,
  output logic             byte_ready_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] word_count_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
`ifdef LOADER_ZERO_FILL_EN
  localparam logic [2:0] S_FILL  = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

  logic [2:0]       state_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      asm_q;
  logic [29:0]      idx_q;
  logic             last_q;
  logic             we_q;
  logic [31:0]      waddr_q;
  logic [31:0]      wdata_q;
  logic             ovf_q;
  logic [CNT_W-1:0] count_q;

  logic        accept;
  logic        in_range;
  logic        word_end;
  logic [29:0] idx_inc;
  logic [31:0] pack_word;

  // Handshake, index bounds and the word as it looks with the incoming byte merged.
  always_comb begin
    accept    = (state_q == S_LOAD) && byte_valid_i;
    in_range  = idx_q < DEPTH_IDX;
    idx_inc   = idx_q + 30'd1;
    word_end  = (byte_cnt_q == 2'd3) || byte_last_i;
    pack_word = asm_q;
    case (byte_cnt_q)
      2'd0:    pack_word[31:24] = byte_i;
      2'd1:    pack_word[23:16] = byte_i;
      2'd2:    pack_word[15:8]  = byte_i;
      default: pack_word[7:0]   = byte_i;
    endcase
  end

  // Loader FSM; the write strobe is registered so it lines up with WRITE/FILL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'd0;
      idx_q      <= 30'd0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            idx_q      <= 30'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            last_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (word_end) begin
              state_q <= S_WRITE;
              last_q  <= byte_last_i;
              if (in_range) begin
                we_q    <= 1'b1;
                waddr_q <= {idx_q, 2'b00};
                wdata_q <= pack_word;
              end
            end else begin
              asm_q      <= pack_word;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          idx_q      <= idx_inc;
          byte_cnt_q <= 2'd0;
          asm_q      <= 32'd0;
          if (in_range) begin
            count_q <= count_q + 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
          if (last_q) begin
`ifdef LOADER_ZERO_FILL_EN
            if (idx_inc < DEPTH_IDX) begin
              state_q <= S_FILL;
              we_q    <= 1'b1;
              waddr_q <= {idx_inc, 2'b00};
              wdata_q <= 32'd0;
            end else begin
              state_q <= S_DONE;
            end
`else
            state_q <= S_DONE;
`endif
          end else begin
            state_q <= S_LOAD;
          end
        end
`ifdef LOADER_ZERO_FILL_EN
        S_FILL: begin
          idx_q <= idx_inc;
          if (idx_inc < DEPTH_IDX) begin
            we_q    <= 1'b1;
            waddr_q <= {idx_inc, 2'b00};
            wdata_q <= 32'd0;
          end else begin
            state_q <= S_DONE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from state; write port driven from registers.
  always_comb begin
    byte_ready_o = (state_q == S_LOAD);
    cpu_hold_o   = (state_q == S_LOAD) || (state_q == S_WRITE);
`ifdef LOADER_ZERO_FILL_EN
    cpu_hold_o   = cpu_hold_o || (state_q == S_FILL);
`endif
    done_o       = (state_q == S_DONE);
    we_o         = we_q;
    waddr_o      = waddr_q;
    wdata_o      = wdata_q;
    ovf_o        = ovf_q;
    word_count_o = count_q;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Reference model expands each program into the expected list of memory writes.
module tb_instr_mem_loader;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [7:0]       byte_i;
  logic             byte_valid_i;
  logic             byte_last_i;
  logic             byte_ready_o;
  logic             we_o;
  logic [31:0]      waddr_o;
  logic [31:0]      wdata_o;
  logic             cpu_hold_o;
  logic             done_o;
  logic             ovf_o;
  logic [CNT_W-1:0] word_count_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] obs_q[$];
  logic [7:0]  prog[$];

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_last_i(byte_last_i),
    .byte_ready_o(byte_ready_o),
    .we_o(we_o),
    .waddr_o(waddr_o),
    .wdata_o(wdata_o),
    .cpu_hold_o(cpu_hold_o),
    .done_o(done_o),
    .ovf_o(ovf_o),
    .word_count_o(word_count_o)
  );

  always @(negedge clk) begin
    if (we_o) obs_q.push_back({waddr_o, wdata_o});
  end

  task automatic chk(input string tag, input logic [95:0] o,
                     input logic [95:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    obs_q.delete();
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit l);
    int n = 0;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    @(negedge clk);
    while (!byte_ready_o && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (n >= 30) chk("ready_timeout", 96'(n), 96'd0);
    byte_i       = b;
    byte_valid_i = 1'b1;
    byte_last_i  = l;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    byte_i       = $urandom();
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done_o && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (n >= 400) chk("done_timeout", 96'(n), 96'd0);
  endtask

  task automatic check_prog(input string tag);
    logic [63:0] exp_q[$];
    logic [31:0] w;
    int nw;
    nw = (prog.size() + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < prog.size())
          w = w | (32'(prog[4 * k + j]) << (24 - 8 * j));
      end
      if (k < DEPTH) exp_q.push_back({32'(4 * k), w});
    end
`ifdef LOADER_ZERO_FILL_EN
    for (int k = nw; k < DEPTH; k++) exp_q.push_back({32'(4 * k), 32'd0});
`endif
    chk({tag, "_nwrites"}, 96'(obs_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 96'(obs_q[i]), 96'(exp_q[i]));
    chk({tag, "_count"}, 96'(word_count_o),
        96'((nw < DEPTH) ? nw : DEPTH));
    chk({tag, "_ovf"}, 96'(ovf_o), 96'(nw > DEPTH));
    chk({tag, "_done"}, 96'({done_o, cpu_hold_o, byte_ready_o, we_o}),
        96'(4'b1000));
  endtask

  task automatic run_prog(input string tag);
    start_load();
    for (int i = 0; i < prog.size(); i++)
      send_byte(prog[i], i == prog.size() - 1);
    wait_done();
    check_prog(tag);
  endtask

  task automatic gen_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_i       = 8'd0;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_outs", 96'({byte_ready_o, we_o, waddr_o, wdata_o,
        cpu_hold_o, done_o, ovf_o, word_count_o}), 96'd0);
    byte_valid_i = 1'b1;
    byte_i       = 8'hA5;
    repeat (2) @(negedge clk);
    chk("idle_ready", 96'({byte_ready_o, cpu_hold_o, we_o}), 96'd0);
    byte_valid_i = 1'b0;

    prog = '{8'h8C, 8'h01, 8'h00, 8'h04};
    start_load();
    @(negedge clk);
    chk("load_hold", 96'({cpu_hold_o, byte_ready_o, done_o}), 96'(3'b110));
    for (int i = 0; i < 4; i++) send_byte(prog[i], i == 3);
    @(negedge clk);
    chk("t2_we", 96'({we_o, waddr_o, wdata_o}), {31'd0, 1'b1, 32'd0, 32'h8C010004});
`ifndef LOADER_ZERO_FILL_EN
    @(negedge clk);
    chk("t2_done_next", 96'({done_o, we_o, word_count_o}), 96'({1'b1, 1'b0, 6'd1}));
`endif
    wait_done();
    check_prog("t2");

    prog = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    run_prog("t3");

    for (int r = 0; r < 6; r++) begin
      gen_prog($urandom_range(1, 40));
      run_prog($sformatf("rnd%0d", r));
    end

    gen_prog(132);
    run_prog("ovf33");
    gen_prog(128);
    run_prog("full32");
    gen_prog(9);
    run_prog("after_ovf");

    gen_prog(10);
    start_load();
    for (int i = 0; i < 10; i++) send_byte(prog[i], 1'b0);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 96'({byte_ready_o, we_o, waddr_o, wdata_o,
        cpu_hold_o, done_o, ovf_o, word_count_o}), 96'd0);
    chk("rst_mid_writes", 96'(obs_q.size()), 96'd2);
    repeat (3) @(negedge clk);
    chk("rst_mid_quiet", 96'(obs_q.size()), 96'd2);
    gen_prog(12);
    run_prog("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
